// File: rtl/frogger_life_manager.sv
// Frogger life manager: turns collision / goal events into lives, score, freeze window,
// frog respawn pulse and game-over state. Every output is registered.
module frogger_life_manager #(
    parameter int unsigned NUM_LIVES     = 3,
    parameter int unsigned FREEZE_CYCLES = 25_000_000,
    parameter int unsigned GUARD_CYCLES  = 2
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Collided,
    input  logic       i_Frog_Win,
    input  logic       i_Restart,
    output logic       o_Respawn,
    output logic       o_Freeze,
    output logic [2:0] o_Lives,
    output logic [7:0] o_Score,
    output logic       o_Game_Over
);

    localparam int unsigned CNT_MAX = (FREEZE_CYCLES > GUARD_CYCLES) ? FREEZE_CYCLES
                                                                     : GUARD_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] FREEZE_LOAD = CNT_W'(FREEZE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GUARD_LOAD  = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [2:0]       LIVES_INIT  = 3'(NUM_LIVES);
    localparam logic [7:0]       SCORE_MAX   = 8'hFF;

    localparam logic [2:0] ST_PLAY      = 3'd0;
    localparam logic [2:0] ST_HIT       = 3'd1;
    localparam logic [2:0] ST_RESPAWN   = 3'd2;
    localparam logic [2:0] ST_GUARD     = 3'd3;
    localparam logic [2:0] ST_GAME_OVER = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       lives_q, lives_d;
    logic [7:0]       score_q, score_d;
    logic             respawn_q, respawn_d;
    logic             freeze_q, freeze_d;
    logic             game_over_q, game_over_d;

    // Next state, counter, lives and score; restart outranks collision, collision outranks win.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lives_d = lives_q;
        score_d = score_q;

        if (i_Restart) begin
            lives_d = LIVES_INIT;
            score_d = 8'd0;
            // A restart held into RESPAWN skips straight to GUARD so the respawn
            // pulse can never last two cycles.
            if (state_q == ST_RESPAWN) begin
                state_d = ST_GUARD;
                cnt_d   = GUARD_LOAD;
            end else begin
                state_d = ST_RESPAWN;
                cnt_d   = '0;
            end
        end else begin
            case (state_q)
                ST_PLAY: begin
                    if (i_Collided) begin
                        // Last life lost (or none left): go straight to game over.
                        if (lives_q <= 3'd1) begin
                            lives_d = 3'd0;
                            state_d = ST_GAME_OVER;
                            cnt_d   = '0;
                        end else begin
                            lives_d = lives_q - 3'd1;
                            state_d = ST_HIT;
                            cnt_d   = FREEZE_LOAD;
                        end
                    end else if (i_Frog_Win) begin
                        if (score_q != SCORE_MAX) begin
                            score_d = score_q + 8'd1;
                        end
                        state_d = ST_RESPAWN;
                        cnt_d   = '0;
                    end
                end
                ST_HIT: begin
                    if (cnt_q == '0) begin
                        state_d = ST_RESPAWN;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                ST_RESPAWN: begin
                    state_d = ST_GUARD;
                    cnt_d   = GUARD_LOAD;
                end
                ST_GUARD: begin
                    // Collision flags here may still reflect the pre-respawn position.
                    if (cnt_q == '0) begin
                        state_d = ST_PLAY;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                ST_GAME_OVER: begin
                    state_d = ST_GAME_OVER;
                end
                default: begin
                    state_d = ST_PLAY;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output flags are decoded from the state being entered so they line up with it.
    always_comb begin
        respawn_d   = (state_d == ST_RESPAWN);
        freeze_d    = (state_d != ST_PLAY);
        game_over_d = (state_d == ST_GAME_OVER);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q     <= ST_PLAY;
            cnt_q       <= '0;
            lives_q     <= LIVES_INIT;
            score_q     <= 8'd0;
            respawn_q   <= 1'b0;
            freeze_q    <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lives_q     <= lives_d;
            score_q     <= score_d;
            respawn_q   <= respawn_d;
            freeze_q    <= freeze_d;
            game_over_q <= game_over_d;
        end
    end

    assign o_Respawn   = respawn_q;
    assign o_Freeze    = freeze_q;
    assign o_Lives     = lives_q;
    assign o_Score     = score_q;
    assign o_Game_Over = game_over_q;

endmodule

// File: tb/tb_frogger_life_manager.sv
// Self-checking bench for frogger_life_manager: vector table, hand sequences for
// reset / game over / score saturation, then random stimulus against a schedule model.
module tb_frogger_life_manager;

    localparam int unsigned NL = 3;
    localparam int unsigned FC = 4;
    localparam int unsigned GC = 2;

    logic       i_Clk;
    logic       i_Rst_L;
    logic       i_Collided;
    logic       i_Frog_Win;
    logic       i_Restart;
    logic       o_Respawn;
    logic       o_Freeze;
    logic [2:0] o_Lives;
    logic [7:0] o_Score;
    logic       o_Game_Over;

    int checks = 0;
    int errors = 0;

    frogger_life_manager #(
        .NUM_LIVES    (NL),
        .FREEZE_CYCLES(FC),
        .GUARD_CYCLES (GC)
    ) dut (
        .i_Clk      (i_Clk),
        .i_Rst_L    (i_Rst_L),
        .i_Collided (i_Collided),
        .i_Frog_Win (i_Frog_Win),
        .i_Restart  (i_Restart),
        .o_Respawn  (o_Respawn),
        .o_Freeze   (o_Freeze),
        .o_Lives    (o_Lives),
        .o_Score    (o_Score),
        .o_Game_Over(o_Game_Over)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    typedef struct {
        logic r;
        logic c;
        logic w;
        int   lives;
        int   score;
        logic frz;
        logic rsp;
        logic go;
    } vec_t;

    // One entry per future cycle while the frog is busy: expected freeze/respawn levels.
    typedef struct packed {
        logic frz;
        logic rsp;
    } sched_t;

    sched_t sched[$];
    int     m_lives;
    int     m_score;
    logic   m_go;
    logic   m_frz;
    logic   m_rsp;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input int lives, input int score,
                           input logic frz, input logic rsp, input logic go);
        chk({tag, ".lives"}, int'(o_Lives), lives);
        chk({tag, ".score"}, int'(o_Score), score);
        chk({tag, ".freeze"}, int'(o_Freeze), int'(frz));
        chk({tag, ".respawn"}, int'(o_Respawn), int'(rsp));
        chk({tag, ".game_over"}, int'(o_Game_Over), int'(go));
    endtask

    task automatic step();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic c, input logic w);
        i_Restart  = r;
        i_Collided = c;
        i_Frog_Win = w;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0);
        i_Rst_L = 1'b0;
        step();
        step();
        i_Rst_L = 1'b1;
        step();
    endtask

    task automatic model_init();
        sched.delete();
        m_lives = NL;
        m_score = 0;
        m_go    = 1'b0;
        m_frz   = 1'b0;
        m_rsp   = 1'b0;
    endtask

    task automatic push_n(input logic frz, input logic rsp, input int n);
        sched_t e;
        e.frz = frz;
        e.rsp = rsp;
        for (int k = 0; k < n; k++) sched.push_back(e);
    endtask

    // Model of one clock edge: events enqueue the whole busy period; a busy frog ignores play.
    task automatic model_step(input logic r, input logic c, input logic w);
        sched_t e;
        if (r) begin
            m_lives = NL;
            m_score = 0;
            m_go    = 1'b0;
            sched.delete();
            if (!m_rsp) push_n(1'b1, 1'b1, 1);
            push_n(1'b1, 1'b0, GC);
            push_n(1'b0, 1'b0, 1);
        end else if (sched.size() != 0 || m_go) begin
            // busy or game over: play inputs ignored
        end else if (c) begin
            if (m_lives <= 1) begin
                m_lives = 0;
                m_go    = 1'b1;
            end else begin
                m_lives = m_lives - 1;
                push_n(1'b1, 1'b0, FC);
                push_n(1'b1, 1'b1, 1);
                push_n(1'b1, 1'b0, GC);
                push_n(1'b0, 1'b0, 1);
            end
        end else if (w) begin
            m_score = (m_score >= 255) ? 255 : m_score + 1;
            push_n(1'b1, 1'b1, 1);
            push_n(1'b1, 1'b0, GC);
            push_n(1'b0, 1'b0, 1);
        end

        if (sched.size() != 0) begin
            e     = sched.pop_front();
            m_frz = e.frz;
            m_rsp = e.rsp;
        end else begin
            m_frz = m_go;
            m_rsp = 1'b0;
        end
    endtask

    task automatic do_hit_and_recover();
        drive(1'b0, 1'b1, 1'b0);
        step();
        drive(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < FC + GC + 2; k++) step();
    endtask

    vec_t tbl[25];

    initial begin
        // Single hit, win, tie, then game over and restart from a fresh reset.
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 2, 0, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 2, 0, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 2, 0, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 2, 0, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 2, 0, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 2, 0, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 2, 0, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 2, 0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 2, 0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 2, 1, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 2, 1, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 2, 1, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 2, 1, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 1'b1, 1, 1, 1'b1, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1, 1, 1'b1, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 1, 1, 1'b1, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 1, 1, 1'b1, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 1'b0, 1'b1, 1, 1, 1'b1, 1'b1, 1'b0};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 1, 1, 1'b1, 1'b0, 1'b0};
        tbl[19] = '{1'b0, 1'b0, 1'b0, 1, 1, 1'b1, 1'b0, 1'b0};
        tbl[20] = '{1'b0, 1'b0, 1'b0, 1, 1, 1'b0, 1'b0, 1'b0};
        tbl[21] = '{1'b0, 1'b1, 1'b0, 0, 1, 1'b1, 1'b0, 1'b1};
        tbl[22] = '{1'b0, 1'b1, 1'b0, 0, 1, 1'b1, 1'b0, 1'b1};
        tbl[23] = '{1'b1, 1'b0, 1'b0, 3, 0, 1'b1, 1'b1, 1'b0};
        tbl[24] = '{1'b0, 1'b0, 1'b0, 3, 0, 1'b1, 1'b0, 1'b0};

        i_Rst_L = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        #2;

        // Reset applied with no clock edge: outputs must settle immediately.
        i_Rst_L = 1'b0;
        #1;
        chk_all("reset_async", 3, 0, 1'b0, 1'b0, 1'b0);
        do_reset();
        chk_all("reset_release", 3, 0, 1'b0, 1'b0, 1'b0);

        // Vector table.
        for (int i = 0; i < 25; i++) begin
            drive(tbl[i].r, tbl[i].c, tbl[i].w);
            step();
            chk_all($sformatf("tbl[%0d]", i), tbl[i].lives, tbl[i].score,
                    tbl[i].frz, tbl[i].rsp, tbl[i].go);
        end

        // Mid-cycle reset from a busy state (table left the frog in GUARD).
        @(negedge i_Clk);
        i_Rst_L = 1'b0;
        #1;
        chk_all("reset_midcycle", 3, 0, 1'b0, 1'b0, 1'b0);
        do_reset();

        // Game over after three hits; further collisions do nothing; restart revives.
        do_hit_and_recover();
        do_hit_and_recover();
        chk_all("two_hits", 1, 0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        step();
        chk_all("third_hit", 0, 0, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b1, k[0]);
            step();
            chk_all("game_over_hold", 0, 0, 1'b1, 1'b0, 1'b1);
        end
        drive(1'b1, 1'b0, 1'b0);
        step();
        chk_all("restart", 3, 0, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        step();
        chk_all("restart_guard", 3, 0, 1'b1, 1'b0, 1'b0);
        step();
        step();
        chk_all("restart_play", 3, 0, 1'b0, 1'b0, 1'b0);

        // 260 wins: score saturates at 255, each win respawns with no hit delay.
        for (int i = 0; i < 260; i++) begin
            drive(1'b0, 1'b0, 1'b1);
            step();
            drive(1'b0, 1'b0, 1'b0);
            chk("win.respawn", int'(o_Respawn), 1);
            chk("win.score", int'(o_Score), (i + 1 > 255) ? 255 : i + 1);
            step();
            chk("win.respawn_one_cycle", int'(o_Respawn), 0);
            step();
            step();
            chk("win.back_to_play", int'(o_Freeze), 0);
        end
        chk("wins.lives", int'(o_Lives), 3);
        chk("wins.score_sat", int'(o_Score), 255);

        // Reset during HIT with counter at 2.
        do_reset();
        drive(1'b0, 1'b1, 1'b0);
        step();
        drive(1'b0, 1'b0, 1'b0);
        step();
        chk_all("hit_cnt2", 2, 0, 1'b1, 1'b0, 1'b0);
        #1;
        i_Rst_L = 1'b0;
        #1;
        chk_all("reset_in_hit", 3, 0, 1'b0, 1'b0, 1'b0);
        @(negedge i_Clk);
        i_Rst_L = 1'b1;
        step();
        chk_all("reset_in_hit_play", 3, 0, 1'b0, 1'b0, 1'b0);

        // Random stimulus against the schedule model.
        do_reset();
        model_init();
        for (int i = 0; i < 4000; i++) begin
            logic r, c, w;
            r = ($urandom_range(0, 63) == 0);
            c = ($urandom_range(0, 5) == 0);
            w = ($urandom_range(0, 4) == 0);
            drive(r, c, w);
            step();
            model_step(r, c, w);
            chk_all("rand", m_lives, m_score, m_frz, m_rsp, m_go);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
